// File: rtl/xbar_port_scheduler.sv
// Per-output-port scheduler for the stream crossbar: rotating-priority arbitration
// with packet locking, a per-winner packet budget and a one-entry registered output stage.
module xbar_port_scheduler #(
  parameter int T_DATA_WIDTH = 8,
  parameter int S_DATA_COUNT = 2,
  parameter int MAX_PACKETS  = 8,
  localparam int T_ID___WIDTH = (S_DATA_COUNT > 1) ? $clog2(S_DATA_COUNT) : 1
) (
  input  logic                                      clk,
  input  logic                                      rst_n,
  input  logic [S_DATA_COUNT-1:0]                   req_i,
  input  logic [S_DATA_COUNT-1:0][T_DATA_WIDTH-1:0] s_data_i,
  input  logic [S_DATA_COUNT-1:0]                   s_last_i,
  output logic [S_DATA_COUNT-1:0]                   s_ready_o,
  output logic [T_DATA_WIDTH-1:0]                   m_data_o,
  output logic [T_ID___WIDTH-1:0]                   m_id_o,
  output logic                                      m_last_o,
  output logic                                      m_valid_o,
  input  logic                                      m_ready_i
);

  localparam int CNT_W = $clog2(MAX_PACKETS + 1);

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } state_e;

  state_e                  state_q, state_d;
  logic [T_ID___WIDTH-1:0] owner_q, owner_d;
  logic [T_ID___WIDTH-1:0] ptr_q, ptr_d;
  logic [CNT_W-1:0]        pkt_cnt_q, pkt_cnt_d;
  logic [T_DATA_WIDTH-1:0] m_data_q, m_data_d;
  logic [T_ID___WIDTH-1:0] m_id_q, m_id_d;
  logic                    m_last_q, m_last_d;
  logic                    m_valid_q, m_valid_d;

  logic                    slot_free_s;
  logic                    accept_s;
  logic [T_ID___WIDTH-1:0] winner_s;
  logic [CNT_W-1:0]        pkt_inc_s;

  // Rotating search: lowest requester at or above ptr wins, else lowest below ptr.
  always_comb begin
    winner_s = '0;
    for (int i = S_DATA_COUNT - 1; i >= 0; i--) begin
      winner_s = (req_i[i] && (T_ID___WIDTH'(i) < ptr_q)) ? T_ID___WIDTH'(i) : winner_s;
    end
    for (int i = S_DATA_COUNT - 1; i >= 0; i--) begin
      winner_s = (req_i[i] && (T_ID___WIDTH'(i) >= ptr_q)) ? T_ID___WIDTH'(i) : winner_s;
    end
  end

  // Source-side handshake: only the locked owner sees ready, gated by the output slot.
  always_comb begin
    slot_free_s = ~m_valid_q | m_ready_i;
    s_ready_o   = '0;
    if (state_q == ST_LOCKED) begin
      s_ready_o[owner_q] = slot_free_s;
    end else begin
      s_ready_o = '0;
    end
    accept_s = (state_q == ST_LOCKED) && req_i[owner_q] && slot_free_s;
  end

  // Next-state, packet budget and output stage.
  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    ptr_d     = ptr_q;
    pkt_cnt_d = pkt_cnt_q;
    m_data_d  = m_data_q;
    m_id_d    = m_id_q;
    m_last_d  = m_last_q;
    m_valid_d = m_valid_q;
    pkt_inc_s = pkt_cnt_q + CNT_W'(1);

    case (state_q)
      ST_IDLE: begin
        if (|req_i) begin
          owner_d = winner_s;
          state_d = ST_LOCKED;
          if (winner_s != owner_q) begin
            pkt_cnt_d = '0;
          end else begin
            pkt_cnt_d = pkt_cnt_q;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_LOCKED: begin
        if (accept_s && s_last_i[owner_q]) begin
          state_d = ST_IDLE;
          // Budget exhausted: hand priority to the next index after the owner.
          if (pkt_inc_s == CNT_W'(MAX_PACKETS)) begin
            pkt_cnt_d = '0;
            if (owner_q == T_ID___WIDTH'(S_DATA_COUNT - 1)) begin
              ptr_d = '0;
            end else begin
              ptr_d = owner_q + T_ID___WIDTH'(1);
            end
          end else begin
            pkt_cnt_d = pkt_inc_s;
            ptr_d     = owner_q;
          end
        end else begin
          state_d = ST_LOCKED;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (accept_s) begin
      m_data_d  = s_data_i[owner_q];
      m_id_d    = owner_q;
      m_last_d  = s_last_i[owner_q];
      m_valid_d = 1'b1;
    end else if (m_ready_i) begin
      m_valid_d = 1'b0;
    end else begin
      m_valid_d = m_valid_q;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      owner_q   <= '0;
      ptr_q     <= '0;
      pkt_cnt_q <= '0;
      m_data_q  <= '0;
      m_id_q    <= '0;
      m_last_q  <= 1'b0;
      m_valid_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      ptr_q     <= ptr_d;
      pkt_cnt_q <= pkt_cnt_d;
      m_data_q  <= m_data_d;
      m_id_q    <= m_id_d;
      m_last_q  <= m_last_d;
      m_valid_q <= m_valid_d;
    end
  end

  assign m_data_o  = m_data_q;
  assign m_id_o    = m_id_q;
  assign m_last_o  = m_last_q;
  assign m_valid_o = m_valid_q;

endmodule

// File: tb/tb_xbar_port_scheduler.sv
// Scoreboard bench for xbar_port_scheduler: queued source models feed three
// instances (S=2/MAX=8, S=2/MAX=2, S=3/MAX=1); expected beats are queued up front.
module tb_xbar_port_scheduler;

  localparam int W = 8;

  typedef struct packed {
    logic [1:0]   id;
    logic [W-1:0] data;
    logic         last;
  } beat_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst_n;
  logic [2:0]        req;
  logic [2:0][W-1:0] sdata;
  logic [2:0]        slast;
  logic              m_ready;

  logic [1:0] a_sready, b_sready;
  logic [2:0] c_sready;
  logic [W-1:0] a_data, b_data, c_data;
  logic [0:0] a_id, b_id;
  logic [1:0] c_id;
  logic a_last, b_last, c_last, a_valid, b_valid, c_valid;

  xbar_port_scheduler #(.T_DATA_WIDTH(W), .S_DATA_COUNT(2), .MAX_PACKETS(8)) dut_a (
    .clk(clk), .rst_n(rst_n), .req_i(req[1:0]), .s_data_i(sdata[1:0]), .s_last_i(slast[1:0]),
    .s_ready_o(a_sready), .m_data_o(a_data), .m_id_o(a_id), .m_last_o(a_last),
    .m_valid_o(a_valid), .m_ready_i(m_ready));

  xbar_port_scheduler #(.T_DATA_WIDTH(W), .S_DATA_COUNT(2), .MAX_PACKETS(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .req_i(req[1:0]), .s_data_i(sdata[1:0]), .s_last_i(slast[1:0]),
    .s_ready_o(b_sready), .m_data_o(b_data), .m_id_o(b_id), .m_last_o(b_last),
    .m_valid_o(b_valid), .m_ready_i(m_ready));

  xbar_port_scheduler #(.T_DATA_WIDTH(W), .S_DATA_COUNT(3), .MAX_PACKETS(1)) dut_c (
    .clk(clk), .rst_n(rst_n), .req_i(req), .s_data_i(sdata), .s_last_i(slast),
    .s_ready_o(c_sready), .m_data_o(c_data), .m_id_o(c_id), .m_last_o(c_last),
    .m_valid_o(c_valid), .m_ready_i(m_ready));

  int         sel;
  logic       obs_valid, obs_last;
  logic [W-1:0] obs_data;
  logic [1:0] obs_id;
  logic [2:0] obs_sready;

  always_comb begin
    case (sel)
      0: begin
        obs_valid = a_valid; obs_data = a_data; obs_id = {1'b0, a_id};
        obs_last = a_last; obs_sready = {1'b0, a_sready};
      end
      1: begin
        obs_valid = b_valid; obs_data = b_data; obs_id = {1'b0, b_id};
        obs_last = b_last; obs_sready = {1'b0, b_sready};
      end
      default: begin
        obs_valid = c_valid; obs_data = c_data; obs_id = c_id;
        obs_last = c_last; obs_sready = c_sready;
      end
    endcase
  end

  int total = 0;
  int bad = 0;
  int cyc = 0;
  logic [2:0] en;
  logic [8:0] q0[$], q1[$], q2[$];
  beat_t exp_q[$];
  int xfer_cyc[$];
  logic smp_valid;
  logic [2:0] smp_sready;
  logic sr1_seen;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=0x%0h want=0x%0h", tag, got, want);
    end
  endtask

  task automatic drive_srcs();
    req = 3'b000; sdata = '0; slast = 3'b000;
    if (q0.size() > 0) begin req[0] = en[0]; sdata[0] = q0[0][7:0]; slast[0] = q0[0][8]; end
    if (q1.size() > 0) begin req[1] = en[1]; sdata[1] = q1[0][7:0]; slast[1] = q1[0][8]; end
    if (q2.size() > 0) begin req[2] = en[2]; sdata[2] = q2[0][7:0]; slast[2] = q2[0][8]; end
  endtask

  task automatic send(input int src, input logic [W-1:0] d, input logic l);
    case (src)
      0: q0.push_back({l, d});
      1: q1.push_back({l, d});
      default: q2.push_back({l, d});
    endcase
  endtask

  task automatic exp_beat(input logic [1:0] id, input logic [W-1:0] d, input logic l);
    beat_t b;
    b.id = id; b.data = d; b.last = l;
    exp_q.push_back(b);
  endtask

  task automatic clear_all();
    q0.delete(); q1.delete(); q2.delete();
    exp_q.delete(); xfer_cyc.delete();
    en = 3'b000; cyc = 0; sr1_seen = 1'b0;
    drive_srcs();
  endtask

  // One clock: sample/score at negedge, then update source queues after the edge.
  task automatic tick();
    logic [2:0] acc;
    beat_t e;
    @(negedge clk);
    cyc++;
    acc = req & obs_sready;
    sr1_seen = sr1_seen | obs_sready[1];
    if (obs_valid && !m_ready) begin
      check_eq("stall_sready", obs_sready, 3'b000);
      if (exp_q.size() > 0) check_eq("hold_data", obs_data, exp_q[0].data);
    end
    if (obs_valid && m_ready) begin
      check_eq("beat_expected", exp_q.size() > 0, 1'b1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check_eq("beat_id", obs_id, e.id);
        check_eq("beat_data", obs_data, e.data);
        check_eq("beat_last", obs_last, e.last);
        xfer_cyc.push_back(cyc);
      end
    end
    smp_valid = obs_valid;
    smp_sready = obs_sready;
    @(posedge clk);
    #1;
    if (acc[0]) void'(q0.pop_front());
    if (acc[1]) void'(q1.pop_front());
    if (acc[2]) void'(q2.pop_front());
    drive_srcs();
  endtask

  task automatic run_drain(input int budget);
    for (int k = 0; k < budget && exp_q.size() > 0; k++) tick();
    check_eq("drain_left", exp_q.size(), 0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    m_ready = 1'b1;
    clear_all();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    sel = 0;
    en = 3'b000;
    do_reset();

    // 1: single source, 3-beat packet on the MAX_PACKETS=8 instance.
    check_eq("rst_valid", obs_valid, 1'b0);
    check_eq("rst_data", obs_data, 8'h00);
    check_eq("rst_id", obs_id, 2'd0);
    check_eq("rst_last", obs_last, 1'b0);
    check_eq("rst_sready", obs_sready, 3'b000);
    send(0, 8'hA0, 1'b0); send(0, 8'hA1, 1'b0); send(0, 8'hA2, 1'b1);
    exp_beat(2'd0, 8'hA0, 1'b0); exp_beat(2'd0, 8'hA1, 1'b0); exp_beat(2'd0, 8'hA2, 1'b1);
    en = 3'b001; drive_srcs();
    run_drain(20);
    check_eq("t1_nbeats", xfer_cyc.size(), 3);
    if (xfer_cyc.size() == 3) begin
      check_eq("t1_latency", xfer_cyc[0], 3);
      check_eq("t1_gap0", xfer_cyc[1] - xfer_cyc[0], 1);
      check_eq("t1_gap1", xfer_cyc[2] - xfer_cyc[1], 1);
    end
    check_eq("t1_sready1", sr1_seen, 1'b0);

    // 2: MAX_PACKETS=2, both sources with single-beat packets.
    sel = 1; do_reset();
    for (int i = 0; i < 4; i++) begin
      send(0, 8'h10 + 8'(i), 1'b1);
      send(1, 8'h20 + 8'(i), 1'b1);
    end
    exp_beat(2'd0, 8'h10, 1'b1); exp_beat(2'd0, 8'h11, 1'b1);
    exp_beat(2'd1, 8'h20, 1'b1); exp_beat(2'd1, 8'h21, 1'b1);
    exp_beat(2'd0, 8'h12, 1'b1); exp_beat(2'd0, 8'h13, 1'b1);
    exp_beat(2'd1, 8'h22, 1'b1); exp_beat(2'd1, 8'h23, 1'b1);
    en = 3'b011; drive_srcs();
    run_drain(40);
    check_eq("t2_nbeats", xfer_cyc.size(), 8);
    for (int i = 1; i < xfer_cyc.size(); i++) check_eq("t2_gap", xfer_cyc[i] - xfer_cyc[i-1], 2);

    // 3: backpressure on src1 mid-packet.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      send(1, 8'h30 + 8'(i), i == 3);
      exp_beat(2'd1, 8'h30 + 8'(i), i == 3);
    end
    en = 3'b010; drive_srcs();
    repeat (3) tick();
    m_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_eq("t3_stall_valid", smp_valid, 1'b1);
    end
    m_ready = 1'b1;
    run_drain(20);
    check_eq("t3_nbeats", xfer_cyc.size(), 4);

    // 4: owner drops request mid-packet while src0 waits.
    do_reset();
    send(1, 8'h40, 1'b0); send(1, 8'h41, 1'b0); send(1, 8'h42, 1'b1);
    send(0, 8'h50, 1'b1);
    exp_beat(2'd1, 8'h40, 1'b0); exp_beat(2'd1, 8'h41, 1'b0); exp_beat(2'd1, 8'h42, 1'b1);
    exp_beat(2'd0, 8'h50, 1'b1);
    en = 3'b010; drive_srcs();
    tick();
    en = 3'b011; drive_srcs();
    tick();
    en = 3'b001; drive_srcs();
    tick();
    check_eq("t4_drop_sready0", smp_sready, 3'b010);
    tick();
    check_eq("t4_drop_sready1", smp_sready, 3'b010);
    check_eq("t4_drop_valid", smp_valid, 1'b0);
    en = 3'b011; drive_srcs();
    run_drain(20);

    // 5: asynchronous reset with a beat in flight.
    do_reset();
    send(1, 8'h60, 1'b0); send(1, 8'h61, 1'b0); send(1, 8'h62, 1'b1);
    exp_beat(2'd1, 8'h60, 1'b0);
    en = 3'b010; drive_srcs();
    tick(); tick();
    #2;
    check_eq("t5_pre_valid", obs_valid, 1'b1);
    rst_n = 1'b0;
    #1;
    check_eq("t5_rst_valid", obs_valid, 1'b0);
    check_eq("t5_rst_sready", obs_sready, 3'b000);
    clear_all();
    @(posedge clk);
    #1 rst_n = 1'b1;
    send(0, 8'h70, 1'b1); send(1, 8'h71, 1'b1);
    exp_beat(2'd0, 8'h70, 1'b1); exp_beat(2'd1, 8'h71, 1'b1);
    en = 3'b011; drive_srcs();
    run_drain(20);

    // 6: S=3, MAX_PACKETS=1, sources 0 and 2 requesting.
    sel = 2; do_reset();
    for (int i = 0; i < 4; i++) begin
      send(0, 8'h80 + 8'(i), 1'b1);
      send(2, 8'h90 + 8'(i), 1'b1);
      exp_beat(2'd0, 8'h80 + 8'(i), 1'b1);
      exp_beat(2'd2, 8'h90 + 8'(i), 1'b1);
    end
    en = 3'b111; drive_srcs();
    run_drain(60);
    check_eq("t6_pkt_cnt", dut_c.pkt_cnt_q, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
